// File: rtl/instr_queue_pkg.sv
// Shared defaults and helpers for the instruction queue.
// Consumed by instr_queue and instr_queue_mem via import instr_queue_pkg::*.
package instr_queue_pkg;

  localparam int WORD_W_DEF = 10;
  localparam int OP_W_DEF   = 3;
  localparam int DEPTH_DEF  = 4;

  // Pointer width for a given depth; a depth of 1 still needs one address bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for instr_queue: DEPTH x WORD_W, one synchronous write port,
// one asynchronous read port.
module instr_queue_mem
  import instr_queue_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = ptr_w(DEPTH_DEF)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // control counters, and non-blocking assignment keeps the write ordered
  // against every other flop sampled on the same edge.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue with opcode/operand split and tristate sysbus drive.
// Optional macro INSTR_QUEUE_SEXT_EN selects sign (defined) or zero extension of the operand.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              load_IR,
  input  logic              next_IR,
  input  logic              flush,
  input  logic              Addr_bus,
  inout  wire  [WORD_W-1:0] sysbus,
  output logic [OP_W-1:0]   op,
  output logic              empty,
  output logic              full,
  output logic              ovf
);

  localparam int AW    = ptr_w(DEPTH);
  localparam int CW    = AW + 1;
  localparam int OPD_W = WORD_W - OP_W;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic              push_req, push_ok, pop_ok, mem_we;
  logic [WORD_W-1:0] head_word, bus_val;
  logic [OPD_W-1:0]  operand;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign ovf   = ovf_q;

  // A push is still accepted when full if the head leaves in the same cycle.
  assign pop_ok   = next_IR & ~empty;
  assign push_req = load_IR & ~Addr_bus;
  assign push_ok  = push_req & (~full | pop_ok);
  assign mem_we   = push_ok & ~flush;

  // NOTE: every always_comb output gets its default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_req && full && !pop_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  instr_queue_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (sysbus),
    .raddr (rd_ptr_q),
    .rdata (head_word)
  );

  assign op      = empty ? '0 : head_word[WORD_W-1 -: OP_W];
  assign operand = head_word[OPD_W-1:0];

`ifdef INSTR_QUEUE_SEXT_EN
  assign bus_val = empty ? '0 : {{OP_W{operand[OPD_W-1]}}, operand};
`else
  assign bus_val = empty ? '0 : {{OP_W{1'b0}}, operand};
`endif

  // The bus is only driven while Addr_bus holds off pushes, so no self-sampling.
  assign sysbus = Addr_bus ? bus_val : {WORD_W{1'bz}};

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter WORD_W, default 10, shall set the sysbus and instruction width in bits.
REQ-002 Parameter OP_W, default 3, shall set the opcode field width, taken from the top bits of each instruction.
REQ-003 Parameter DEPTH, default 4, shall set the queue entry count; it must be a power of two and at least 2.
REQ-004 clock  input  1  shall be the single clock; all state updates on its rising edge.
REQ-005 n_reset  input  1  shall be an asynchronous, active-low reset.
REQ-006 load_IR  input  1  shall push the sysbus word into the queue.
REQ-007 next_IR  input  1  shall pop the head entry.
REQ-008 flush  input  1  shall discard all entries (synchronous).
REQ-009 Addr_bus  input  1  shall request that the head operand be driven onto sysbus.
REQ-010 sysbus  inout  WORD_W  shall be the shared tristate system bus.
REQ-011 op  output  OP_W  shall carry the head opcode.
REQ-012 empty, full  output  1 each  shall report queue occupancy.
REQ-013 ovf  output  1  shall be a sticky overflow error flag.

Function
REQ-014 Storage shall be a circular buffer with read pointer, write pointer and a count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-015 A push shall be accepted when load_IR=1, Addr_bus=0 and (not full, or next_IR=1 with the queue not empty); the sysbus value is written at the write pointer.
REQ-016 load_IR shall be ignored while Addr_bus=1, so the block never samples its own drive.
REQ-017 A pop shall be accepted when next_IR=1 and the queue is not empty; a pop on empty shall be a no-op.
REQ-018 A simultaneous accepted push and pop shall leave count unchanged; on empty, only the push takes effect.
REQ-019 Priority shall be flush first, then push/pop; flush clears pointers, count and ovf.
REQ-020 ovf shall set when load_IR=1 and Addr_bus=0 while full with no accepted pop, and that push is dropped.
REQ-021 op shall be combinational from the head entry bits [WORD_W-1:WORD_W-OP_W]; op shall be 0 when empty.
REQ-022 When Addr_bus=1, sysbus shall carry the head operand (bits [WORD_W-OP_W-1:0]) extended to WORD_W; otherwise sysbus shall be high-impedance.
REQ-023 When Addr_bus=1 and the queue is empty, sysbus shall carry all zeros.
REQ-024 Head data shall be visible on op and sysbus in the cycle after the push that filled an empty queue (latency 1 clock).
REQ-025 empty shall equal (count==0) and full shall equal (count==DEPTH), both registered-state derived with no combinational path from inputs.

Reset
REQ-026 While n_reset=0: pointers and count shall be 0; empty=1, full=0, ovf=0, op=0; sysbus follows REQ-022/023.
REQ-027 Entry contents need not be reset; reset mid-operation shall abandon all queued entries immediately.

Configuration
REQ-028 When macro INSTR_QUEUE_SEXT_EN is defined, the operand extension in REQ-022 shall be a sign extension using bit WORD_W-OP_W-1.
REQ-029 When INSTR_QUEUE_SEXT_EN is undefined, the operand extension shall be a zero extension (OP_W zero bits prepended).

Structure
REQ-030 Package instr_queue_pkg shall hold the default WORD_W/OP_W/DEPTH constants and a pointer-width localparam function; ports shall remain parameter-driven.
REQ-031 Storage shall be a sub-module instr_queue_mem (DEPTH x WORD_W, one write port, one asynchronous read port); control stays in instr_queue.

Verification
REQ-032 Reset, then push 10'b101_0110011 -> the next cycle gives op=3'b101 and empty=0; Addr_bus=1 gives sysbus=10'b000_0110011.
REQ-033 Push 4 words with DEPTH=4 -> full=1; a fifth push with no pop -> ovf=1 and the head is unchanged; then flush -> empty=1, ovf=0.
REQ-034 Full queue, load_IR and next_IR in the same cycle -> count stays 4, the head advances and the new word is at the tail; 8 push/pop cycles exercise pointer wrap.
REQ-035 Empty queue, next_IR=1 with Addr_bus=1 -> no state change, sysbus=0, op=0; push and pop together on empty -> one entry.
REQ-036 Head 10'b011_1000001 with Addr_bus=1 -> sysbus=10'h3C1 with INSTR_QUEUE_SEXT_EN defined, 10'h041 without it.
REQ-037 Assert n_reset=0 mid-stream with 3 entries -> empty=1, op=0 immediately (asynchronously), with no clock edge required.
